// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the 5-stage pipeline sequencer.
// Covers the FSM state encoding, PC source selects and the bundled control word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic PC_SEQ = 1'b0;
    localparam logic PC_BR  = 1'b1;

    // One control word per cycle, driven straight onto the output ports
    typedef struct packed {
        logic pc_en;
        logic pc_src;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    // Everything frozen: no loads, no flushes, sequential PC
    localparam ctrl_t CTRL_HOLD = '{pc_en: 1'b0, pc_src: PC_SEQ, if_id_en: 1'b0,
                                    id_ex_en: 1'b0, ex_mem_en: 1'b0,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0};

    // Normal advance: every stage loads, PC moves to PC+1
    localparam ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, pc_src: PC_SEQ, if_id_en: 1'b1,
                                       id_ex_en: 1'b1, ex_mem_en: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for the pipe_ctrl performance counters.
// Sticks at all-ones instead of wrapping; async active-low reset, sync clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] value
);

    // Count up on inc, holding once the counter is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 19-bit, 5-stage processor.
// Turns stall/flush/mem-wait/halt indications into per-stage enables and flushes,
// drains the pipe on halt and freezes it during data-memory waits.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_stall,
    input  logic             is_flush,
    input  logic             mem_busy,
    input  logic             id_halt,
    input  logic             resume,
    output logic             pc_en,
    output logic             pc_src,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    ctrl_t         ctrl;
    logic          stall_hit;
    logic          flush_hit;

    // Mealy decode of controls and next state; the first non-busy MEMWAIT cycle
    // behaves exactly like RUN so hazards are re-evaluated from live inputs
    always_comb begin
        ctrl          = CTRL_HOLD;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        stall_hit     = 1'b0;
        flush_hit     = 1'b0;
        case (state)
            RUN, MEMWAIT: begin
                if (mem_busy) begin
                    state_nxt = MEMWAIT;
                end else begin
                    state_nxt = RUN;
                    ctrl      = CTRL_ADVANCE;
                    if (is_flush) begin
                        ctrl.pc_src      = PC_BR;
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                        flush_hit        = 1'b1;
                    end else if (is_stall) begin
                        ctrl.pc_en       = 1'b0;
                        ctrl.if_id_en    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                        stall_hit        = 1'b1;
                    end else if (id_halt) begin
                        ctrl.pc_en       = 1'b0;
                        ctrl.if_id_flush = 1'b1;
                        state_nxt        = DRAIN;
                        drain_cnt_nxt    = '0;
                    end
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    ctrl             = CTRL_ADVANCE;
                    ctrl.pc_en       = 1'b0;
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    drain_cnt_nxt    = drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign pc_src      = ctrl.pc_src;
    assign if_id_en    = ctrl.if_id_en;
    assign id_ex_en    = ctrl.id_ex_en;
    assign ex_mem_en   = ctrl.ex_mem_en;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign halted      = (state == HALT);

`ifdef PIPE_CTRL_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_hit),
        .clear (1'b0),
        .value (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_hit),
        .clear (1'b0),
        .value (flush_cnt)
    );
`else
    logic unused_hits;
    assign unused_hits = stall_hit ^ flush_hit;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (DRAIN_CYCLES=3).
// Counter checks are compiled in when PIPE_CTRL_PERF_EN is defined (CNT_W=4).
module tb_pipe_ctrl;

    logic clk;
    logic rst_n;
    logic is_stall, is_flush, mem_busy, id_halt, resume;
    logic pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected control words: {pc_en,pc_src,if_id_en,id_ex_en,ex_mem_en,if_id_flush,id_ex_flush,halted}
    localparam logic [7:0] EXP_ADV   = 8'b1011_1000;
    localparam logic [7:0] EXP_HOLD  = 8'b0000_0000;
    localparam logic [7:0] EXP_STALL = 8'b0001_1010;
    localparam logic [7:0] EXP_BR    = 8'b1111_1110;
    localparam logic [7:0] EXP_HLTIN = 8'b0011_1100;
    localparam logic [7:0] EXP_DRAIN = 8'b0011_1110;
    localparam logic [7:0] EXP_HALT  = 8'b0000_0001;

    pipe_ctrl #(
        .DRAIN_CYCLES (3)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .CNT_W        (4)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .is_stall    (is_stall),
        .is_flush    (is_flush),
        .mem_busy    (mem_busy),
        .id_halt     (id_halt),
        .resume      (resume),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic stall, input logic flush, input logic busy,
                                  input logic halt, input logic res);
        is_stall = stall;
        is_flush = flush;
        mem_busy = busy;
        id_halt  = halt;
        resume   = res;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic check_counts(input string tag, input logic [3:0] exp_stall, input logic [3:0] exp_flush);
        checks++;
        assert (stall_cnt === exp_stall && flush_cnt === exp_flush) else begin
            errors++;
            $error("[TB] FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0);
        #10;
        check_output("reset_state", EXP_ADV);
`ifdef PIPE_CTRL_PERF_EN
        check_counts("reset_counts", 4'd0, 4'd0);
`endif
        rst_n = 1'b1;
        tick();
        check_output("idle_run", EXP_ADV);

        // Load-use stall for one cycle
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("load_use", EXP_STALL);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("after_stall", EXP_ADV);
`ifdef PIPE_CTRL_PERF_EN
        check_counts("stall_count", 4'd1, 4'd0);
`endif

        // Branch flush wins over coincident stall
        apply_stimulus(1, 1, 0, 0, 0);
        check_output("branch_vs_stall", EXP_BR);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_counts("flush_count", 4'd1, 4'd1);
`endif

        // Branch flush wins over coincident halt
        apply_stimulus(0, 1, 0, 1, 0);
        check_output("branch_vs_halt", EXP_BR);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("no_drain_after_br", EXP_ADV);

        // Memory wait during a stall, four busy cycles
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 1, 0, 0);
            check_output($sformatf("memwait_%0d", i), EXP_HOLD);
            tick();
        end
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("stall_reeval", EXP_STALL);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("after_memwait", EXP_ADV);
`ifdef PIPE_CTRL_PERF_EN
        check_counts("stall_after_wait", 4'd2, 4'd2);
`endif

        // Halt: 4 edges to halted, flush/resume ignored in DRAIN
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("halt_accept", EXP_HLTIN);
        tick();
        apply_stimulus(0, 1, 0, 1, 1);
        check_output("drain_0_ignores", EXP_DRAIN);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("drain_1", EXP_DRAIN);
        tick();
        check_output("drain_2", EXP_DRAIN);
        tick();
        check_output("halted_4_edges", EXP_HALT);
        apply_stimulus(1, 1, 1, 0, 0);
        tick();
        check_output("halt_holds", EXP_HALT);
        apply_stimulus(0, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("resume_run", EXP_ADV);

        // Halt with one mem_busy cycle in DRAIN: 5 edges
        apply_stimulus(0, 0, 0, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("bdrain_0", EXP_DRAIN);
        tick();
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("bdrain_busy", EXP_HOLD);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("bdrain_1", EXP_DRAIN);
        tick();
        check_output("bdrain_2", EXP_DRAIN);
        tick();
        check_output("halted_5_edges", EXP_HALT);
        apply_stimulus(0, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);

        // Asynchronous reset mid-DRAIN with drain counter at 1
        apply_stimulus(0, 0, 0, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        check_output("pre_reset_drain", EXP_DRAIN);
        rst_n = 1'b0;
        #1;
        check_output("async_reset", EXP_ADV);
`ifdef PIPE_CTRL_PERF_EN
        check_counts("reset_clears", 4'd0, 4'd0);
`endif
        #2;
        rst_n = 1'b1;
        tick();
        check_output("no_partial_drain", EXP_ADV);

`ifdef PIPE_CTRL_PERF_EN
        // Saturation with CNT_W=4
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 0, 0, 0, 0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0);
        check_counts("stall_saturate", 4'd15, 4'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
